time_set_ctrl: RTL

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting front end: synchronizes and debounces five push buttons, then
// runs a small editor FSM over hour/minute/second with confirm-load and idle timeout.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       middle,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic [1:0] mode,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [5:0] set_second,
  output logic       load
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam int unsigned B_LEFT  = 0;
  localparam int unsigned B_RIGHT = 1;
  localparam int unsigned B_DOWN  = 2;
  localparam int unsigned B_UP    = 3;
  localparam int unsigned B_MID   = 4;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    EDIT_SEC  = 2'd3
  } state_t;

  logic [4:0]    raw;
  logic [4:0]    sync1, sync2;
  logic [4:0]    deb, deb_d;
  logic [DW-1:0] cnt [5];
  logic [4:0]    press;
  logic [4:0]    evt;

  state_t        state, state_next;
  logic [4:0]    hour_next;
  logic [5:0]    minute_next, second_next;
  logic [TW-1:0] idle, idle_next;
  logic          load_next;

  assign raw = {middle, up, down, right, left};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any cycle where the synchronized level agrees with the debounced one restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb   <= '0;
      deb_d <= '0;
      for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int unsigned i = 0; i < 5; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + DW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  always_comb begin
    evt = '0;
    if      (press[B_MID])   evt[B_MID]   = 1'b1;
    else if (press[B_UP])    evt[B_UP]    = 1'b1;
    else if (press[B_DOWN])  evt[B_DOWN]  = 1'b1;
    else if (press[B_RIGHT]) evt[B_RIGHT] = 1'b1;
    else if (press[B_LEFT])  evt[B_LEFT]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      set_hour   <= '0;
      set_minute <= '0;
      set_second <= '0;
      idle       <= '0;
      load       <= 1'b0;
    end else begin
      state      <= state_next;
      set_hour   <= hour_next;
      set_minute <= minute_next;
      set_second <= second_next;
      idle       <= idle_next;
      load       <= load_next;
    end
  end

  always_comb begin
    state_next  = state;
    hour_next   = set_hour;
    minute_next = set_minute;
    second_next = set_second;
    idle_next   = idle;
    load_next   = 1'b0;
    case (state)
      NORMAL: begin
        idle_next = '0;
        if (evt[B_MID]) begin
          hour_next   = cur_hour;
          minute_next = cur_minute;
          second_next = cur_second;
          state_next  = EDIT_HOUR;
        end
      end
      default: begin
        if (|evt) begin
          idle_next = '0;
          if (evt[B_MID]) begin
            load_next  = 1'b1;
            state_next = NORMAL;
          end else if (evt[B_RIGHT]) begin
            case (state)
              EDIT_HOUR: state_next = EDIT_MIN;
              EDIT_MIN:  state_next = EDIT_SEC;
              default:   state_next = EDIT_HOUR;
            endcase
          end else if (evt[B_LEFT]) begin
            case (state)
              EDIT_HOUR: state_next = EDIT_SEC;
              EDIT_SEC:  state_next = EDIT_MIN;
              default:   state_next = EDIT_HOUR;
            endcase
          end else if (evt[B_UP]) begin
            case (state)
              EDIT_HOUR: hour_next   = (set_hour   == 5'd23) ? 5'd0 : set_hour   + 5'd1;
              EDIT_MIN:  minute_next = (set_minute == 6'd59) ? 6'd0 : set_minute + 6'd1;
              default:   second_next = (set_second == 6'd59) ? 6'd0 : set_second + 6'd1;
            endcase
          end else begin
            case (state)
              EDIT_HOUR: hour_next   = (set_hour   == 5'd0) ? 5'd23 : set_hour   - 5'd1;
              EDIT_MIN:  minute_next = (set_minute == 6'd0) ? 6'd59 : set_minute - 6'd1;
              default:   second_next = (set_second == 6'd0) ? 6'd59 : set_second - 6'd1;
            endcase
          end
        end else if (idle == TW'(TIMEOUT_CYCLES - 1)) begin
          idle_next  = '0;
          state_next = NORMAL;
        end else begin
          idle_next = idle + TW'(1);
        end
      end
    endcase
  end

  assign mode = state;

endmodule
